// File: rtl/mining_result_tx_pkg.sv
// Shared definitions for the mining result transmitter: frame constants,
// FSM encoding, the FIFO entry layout and the frame checksum helper.
package mining_result_tx_pkg;

  localparam logic [7:0] HDR0        = 8'h55;
  localparam logic [7:0] HDR1        = 8'hAA;
  localparam logic [7:0] TYPE_NONCE  = 8'h01;
  localparam logic [7:0] TYPE_FULL   = 8'h02;
  localparam int         FRAME_BYTES = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  localparam logic KIND_NONCE = 1'b0;
  localparam logic KIND_FULL  = 1'b1;

  typedef struct packed {
    logic        kind;
    logic [31:0] en2;
    logic [31:0] nonce;
  } result_t;

  // XOR of TYPE and the eight payload bytes (frame bytes 2..10)
  function automatic logic [7:0] frame_chk(input logic [7:0] kind,
                                           input logic [31:0] en2,
                                           input logic [31:0] nonce);
    logic [7:0] acc;
    acc = kind;
    for (int i = 0; i < 4; i++) begin
      acc = acc ^ en2[8*i +: 8] ^ nonce[8*i +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/mining_result_fifo.sv
// Synchronous result FIFO with full/empty flags and occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module mining_result_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == {(AW+1){1'b0}});
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // storage array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mining_result_tx.sv
// Buffers nonce-found / space-full events and serializes each one into a
// 12-byte checksummed frame on a valid/ready byte stream.
module mining_result_tx
  import mining_result_tx_pkg::*;
#(
  parameter int DATA_WID      = 32,
  parameter int UART_DATA_WID = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WID-1:0]      iv_mining_extranounce2,
  input  logic [DATA_WID-1:0]      iv_mining_nounce,
  input  logic                     i_mining_nounce_vld,
  input  logic                     i_mining_nounce_full,
  output logic [UART_DATA_WID-1:0] ov_tx_data,
  output logic                     o_tx_vld,
  input  logic                     i_tx_rdy,
  output logic [7:0]               ov_drop_cnt,
  output logic                     o_busy
);

  localparam int          ENTRY_W  = $bits(result_t);
  localparam int          CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int          FRAME_W  = 8 * FRAME_BYTES;
  localparam logic [3:0]  LAST_IDX = 4'(FRAME_BYTES - 1);

  result_t             push_entry;
  result_t             pop_entry;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                pend_drain;

  logic                pend_r;
  logic [DATA_WID-1:0] pend_en2_r;
  logic [DATA_WID-1:0] pend_nonce_r;
  logic [7:0]          drop_r;
  logic [1:0]          state_r;
  logic [3:0]          idx_r;
  logic [FRAME_W-1:0]  frame_r;
  logic                vld_r;
  logic [7:0]          pop_type;

  mining_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // nonce events have priority; a full event waits for a cycle without one
  always_comb begin
    fifo_push  = 1'b0;
    pend_drain = 1'b0;
    push_entry = {ENTRY_W{1'b0}};
    if (i_mining_nounce_vld) begin
      fifo_push        = !fifo_full;
      push_entry.kind  = KIND_NONCE;
      push_entry.en2   = iv_mining_extranounce2;
      push_entry.nonce = iv_mining_nounce;
    end else if ((i_mining_nounce_full || pend_r) && !fifo_full) begin
      fifo_push       = 1'b1;
      pend_drain      = 1'b1;
      push_entry.kind = KIND_FULL;
      if (i_mining_nounce_full) begin
        push_entry.en2   = iv_mining_extranounce2;
        push_entry.nonce = iv_mining_nounce;
      end else begin
        push_entry.en2   = pend_en2_r;
        push_entry.nonce = pend_nonce_r;
      end
    end else begin
      fifo_push  = 1'b0;
      pend_drain = 1'b0;
    end
  end

  // pending space-full event; a newer full pulse simply replaces the payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r       <= 1'b0;
      pend_en2_r   <= {DATA_WID{1'b0}};
      pend_nonce_r <= {DATA_WID{1'b0}};
    end else begin
      if (i_mining_nounce_full) begin
        pend_en2_r   <= iv_mining_extranounce2;
        pend_nonce_r <= iv_mining_nounce;
      end
      if (pend_drain) begin
        pend_r <= 1'b0;
      end else if (i_mining_nounce_full) begin
        pend_r <= 1'b1;
      end
    end
  end

  // saturating overflow counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_r <= 8'h00;
    end else if (i_mining_nounce_vld && fifo_full && (drop_r != 8'hFF)) begin
      drop_r <= drop_r + 8'h01;
    end
  end

  assign fifo_pop = (state_r == ST_IDLE) && !fifo_empty;
  assign pop_type = (pop_entry.kind == KIND_FULL) ? TYPE_FULL : TYPE_NONCE;

  // frame FSM: the byte on the wire is always the top byte of frame_r
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 4'd0;
      frame_r <= {FRAME_W{1'b0}};
      vld_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty) begin
            frame_r <= {HDR0, HDR1, pop_type, pop_entry.en2, pop_entry.nonce,
                        frame_chk(pop_type, pop_entry.en2, pop_entry.nonce)};
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          idx_r   <= 4'd0;
          vld_r   <= 1'b1;
          state_r <= ST_SEND;
        end
        ST_SEND: begin
          if (vld_r && i_tx_rdy) begin
            frame_r <= {frame_r[FRAME_W-9:0], 8'h00};
            if (idx_r == LAST_IDX) begin
              idx_r   <= 4'd0;
              vld_r   <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              idx_r <= idx_r + 4'd1;
            end
          end
        end
        default: begin
          idx_r   <= 4'd0;
          vld_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ov_tx_data  = frame_r[FRAME_W-1 -: UART_DATA_WID];
  assign o_tx_vld    = vld_r;
  assign ov_drop_cnt = drop_r;
  assign o_busy      = (fifo_count != {CNT_W{1'b0}}) || pend_r || (state_r != ST_IDLE);

endmodule

// File: tb/tb_mining_result_tx.sv
// Self-checking bench for mining_result_tx: event-level reference model with
// a per-cycle compare process plus hand-computed frame literals.
module tb_mining_result_tx;

  localparam int DEPTH = 4;
  localparam logic [95:0] EXP_SINGLE = 96'h55AA01_00000007_1A2B3C4D_46;
  localparam logic [95:0] EXP_SIM0   = 96'h55AA01_00000005_00000010_14;
  localparam logic [95:0] EXP_SIM1   = 96'h55AA01_00000005_FFFFFFFF_04;
  localparam logic [95:0] EXP_SIM2   = 96'h55AA02_00000005_FFFFFFFF_07;
  localparam logic [95:0] EXP_OVF4   = 96'h55AA01_00000020_00000005_24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] en2 = 32'd0;
  logic [31:0] nonce = 32'd0;
  logic        nvld = 1'b0;
  logic        nfull = 1'b0;
  logic        tx_rdy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic [7:0]  drop;
  logic        busy;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [95:0] q[$];
  logic [95:0] cur = 96'd0;
  int          m_ph = 0;     // 0 nothing in hand, 1 frame staged, 2 frame on the wire
  int          m_idx = 0;
  logic        m_vld = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_pen2 = 32'd0;
  logic [31:0] m_pnon = 32'd0;
  int          m_drop = 0;
  logic [7:0]  log_q[$];

  always #5 clk = ~clk;

  mining_result_tx dut (
    .clk                    (clk),
    .rst                    (rst),
    .iv_mining_extranounce2 (en2),
    .iv_mining_nounce       (nonce),
    .i_mining_nounce_vld    (nvld),
    .i_mining_nounce_full   (nfull),
    .ov_tx_data             (tx_data),
    .o_tx_vld               (tx_vld),
    .i_tx_rdy               (tx_rdy),
    .ov_drop_cnt            (drop),
    .o_busy                 (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] mk(input logic [7:0] kind, input logic [31:0] e, input logic [31:0] n);
    logic [7:0] b [12];
    logic [7:0] c;
    logic [95:0] f;
    b[0] = 8'h55;
    b[1] = 8'hAA;
    b[2] = kind;
    for (int i = 0; i < 4; i++) begin
      b[3+i] = e[31-8*i -: 8];
      b[7+i] = n[31-8*i -: 8];
    end
    c = 8'h00;
    for (int i = 2; i <= 10; i++) c = c ^ b[i];
    b[11] = c;
    f = 96'd0;
    for (int i = 0; i < 12; i++) f[95-8*i -: 8] = b[i];
    return f;
  endfunction

  function automatic logic [7:0] fbyte(input logic [95:0] f, input int i);
    return f[95-8*i -: 8];
  endfunction

  task automatic model_step();
    bit was_full;
    if (rst) begin
      q.delete();
      m_ph = 0; m_idx = 0; m_vld = 1'b0; m_pend = 1'b0; m_drop = 0;
      return;
    end
    was_full = (q.size() == DEPTH);
    if (m_ph == 2) begin
      if (m_vld && tx_rdy) begin
        m_idx++;
        if (m_idx == 12) begin m_ph = 0; m_vld = 1'b0; m_idx = 0; end
      end
    end else if (m_ph == 1) begin
      m_ph = 2; m_vld = 1'b1; m_idx = 0;
    end else if (q.size() != 0) begin
      cur = q.pop_front();
      m_ph = 1;
    end
    if (nvld) begin
      if (!was_full) q.push_back(mk(8'h01, en2, nonce));
      else if (m_drop < 255) m_drop++;
      if (nfull) begin m_pend = 1'b1; m_pen2 = en2; m_pnon = nonce; end
    end else if (nfull || m_pend) begin
      if (nfull) begin m_pen2 = en2; m_pnon = nonce; end
      if (!was_full) begin q.push_back(mk(8'h02, m_pen2, m_pnon)); m_pend = 1'b0; end
      else m_pend = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("vld", 32'(tx_vld), 32'(m_vld));
    if (m_vld) chk("data", 32'(tx_data), 32'(fbyte(cur, m_idx)));
    chk("drop", 32'(drop), 32'(m_drop));
    chk("busy", 32'(busy), 32'((q.size() != 0) || m_pend || (m_ph != 0)));
    if (tx_vld && tx_rdy) log_q.push_back(tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic v, input logic f, input logic [31:0] e, input logic [31:0] n);
    en2 = e; nonce = n; nvld = v; nfull = f;
    tick();
    nvld = 1'b0; nfull = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || tx_vld) && n < budget) begin tick(); n++; end
    chk("idle_timeout", 32'(busy | tx_vld), 32'd0);
  endtask

  task automatic check_log(input string name, input logic [95:0] exp, input int base);
    chk({name, "_len"}, 32'(log_q.size() >= base + 12), 32'd1);
    if (log_q.size() >= base + 12) begin
      for (int i = 0; i < 12; i++) chk(name, 32'(log_q[base+i]), 32'(exp[95-8*i -: 8]));
    end
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_data", 32'(tx_data), 32'h00);
    chk("rst_vld", 32'(tx_vld), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // single nonce, header two edges after the sampling edge
    tx_rdy = 1'b1;
    log_q.delete();
    pulse(1'b1, 1'b0, 32'h00000007, 32'h1A2B3C4D);
    chk("lat_k", 32'(tx_vld), 32'd0);
    tick();
    chk("lat_k1", 32'(tx_vld), 32'd0);
    tick();
    chk("lat_k2_vld", 32'(tx_vld), 32'd1);
    chk("lat_k2_hdr", 32'(tx_data), 32'h55);
    wait_idle(100);
    check_log("single", EXP_SINGLE, 0);

    // same frame under backpressure (ready one cycle in three)
    log_q.delete();
    tx_rdy = 1'b0;
    pulse(1'b1, 1'b0, 32'h00000007, 32'h1A2B3C4D);
    for (int c = 0; c < 300 && (busy || tx_vld || c < 3); c++) begin
      tx_rdy = (c % 3 == 2);
      tick();
    end
    tx_rdy = 1'b1;
    wait_idle(10);
    check_log("bp", EXP_SINGLE, 0);

    // vld+full together twice (pending payload replaced), then a quiet cycle
    log_q.delete();
    pulse(1'b1, 1'b1, 32'h5, 32'h10);
    pulse(1'b1, 1'b1, 32'h5, 32'hFFFFFFFF);
    wait_idle(200);
    chk("sim_drop", 32'(drop), 32'd0);
    check_log("sim0", EXP_SIM0, 0);
    check_log("sim1", EXP_SIM1, 12);
    check_log("sim2", EXP_SIM2, 24);

    // overflow: one frame is latched in the shifter, four wait in the FIFO
    log_q.delete();
    tx_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) pulse(1'b1, 1'b0, 32'h20, 32'(i));
    tick();
    chk("ovf_drop", 32'(drop), 32'd1);
    tx_rdy = 1'b1;
    wait_idle(200);
    chk("ovf_frames", 32'(log_q.size()), 32'd60);
    check_log("ovf4", EXP_OVF4, 48);

    // saturation after a clean reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_rdy = 1'b0;
    for (int i = 0; i < 305; i++) pulse(1'b1, 1'b0, 32'h30, 32'(i));
    tick();
    chk("sat_drop", 32'(drop), 32'd255);

    // reset while byte 5 of the first frame is on the wire
    log_q.delete();
    tx_rdy = 1'b1;
    n = 0;
    while (log_q.size() < 5 && n < 100) begin tick(); n++; end
    chk("mid_reach", 32'(log_q.size()), 32'd5);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(tx_vld), 32'd0);
    chk("mid_rst_data", 32'(tx_data), 32'h00);
    chk("mid_rst_drop", 32'(drop), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("mid_no_more", 32'(log_q.size()), 32'd5);
    pulse(1'b1, 1'b0, 32'h00000007, 32'h1A2B3C4D);
    wait_idle(100);
    check_log("after_rst", EXP_SINGLE, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
